conv_filter_loader: RTL

- Loads the 3x3 convolution filter for the convolution block at runtime from a weight stream, instead of a simulation-time file preload.
- Accepts K*K weights in row-major order over a valid/ready input and holds them in a register array.
- Presents the weights as a flat bus with a filter_valid qualifier.
- Can stream the stored weights back out over a valid/ready output for readback and checking, making it both writer and reader of the filter store.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/conv_filter_loader_if.sv | 14 +
 rtl/conv_filter_loader_counter.sv | 31 +++
 rtl/conv_filter_loader.sv | 96 +++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the convolution datapath: kernel geometry, weight width,
// and the filter loader's state encoding.
package cnn_pkg;
    localparam int CNN_K      = 3;
    localparam int CNN_DATA_W = 8;
    localparam int CNN_KK     = CNN_K * CNN_K;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t READY = 2'd2;
    localparam state_t DUMP  = 2'd3;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_filter_loader_if.sv
// Weight-in and readback-out valid/ready streams of the filter loader.
interface conv_filter_loader_if #(parameter int DATA_W = 8) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/conv_filter_loader_counter.sv
// Row-major kernel position counter; one instance is shared by load and readback.
module kernel_index_counter #(
    parameter int K     = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);
    localparam logic [IDX_W-1:0] MAX = IDX_W'(K - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == MAX) begin
                col <= '0;
                row <= (row == MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (row == MAX) && (col == MAX);
endmodule

// File: rtl/conv_filter_loader.sv
// Runtime-loadable KxK filter store: written from a weight stream, presented as a
// flat bus, and readable back over an output stream.
module conv_filter_loader
    import cnn_pkg::*;
#(
    parameter int K      = CNN_K,
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     dump_start,
    conv_filter_loader_if.slave      bus,
    output logic [K*K*DATA_W-1:0]    filter_flat,
    output logic                     filter_valid,
    output logic                     load_done,
    output logic                     dump_done,
    output logic                     busy
);
    localparam int KK = K * K;
    localparam int RW = idx_w(K);
    localparam int FW = idx_w(KK);

    state_t                       state_q, state_d;
    logic [RW-1:0]                row, col;
    logic                         last, clear, advance, load_beat, dump_beat;
    logic [FW-1:0]                widx;
    logic [KK-1:0][DATA_W-1:0]    weights;

    kernel_index_counter #(.K(K), .IDX_W(RW)) u_idx (
        .clk(clk), .rst(rst), .clear(clear), .advance(advance),
        .row(row), .col(col), .last(last)
    );

    assign widx    = FW'(row) * FW'(K) + FW'(col);
    assign advance = load_beat | dump_beat;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A start in LOAD restarts the count and drops any beat offered in that cycle.
    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        load_beat = 1'b0;
        dump_beat = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                clear   = 1'b1;
            end
            LOAD: if (start) begin
                clear = 1'b1;
            end else if (bus.in_valid) begin
                load_beat = 1'b1;
                if (last) state_d = READY;
            end
            READY: if (start) begin
                state_d = LOAD;
                clear   = 1'b1;
            end else if (dump_start) begin
                state_d = DUMP;
                clear   = 1'b1;
            end
            DUMP: if (bus.out_ready) begin
                dump_beat = 1'b1;
                if (last) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == LOAD);
        bus.out_valid = (state_q == DUMP);
        busy          = (state_q == LOAD) || (state_q == DUMP);
        filter_valid  = (state_q == READY) || (state_q == DUMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weights   <= '0;
            load_done <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            if (load_beat) weights[widx] <= bus.in_data;
            load_done <= load_beat && last;
            dump_done <= dump_beat && last;
        end
    end

    assign filter_flat  = weights;
    assign bus.out_data = weights[widx];
endmodule
